// File: rtl/lane_renderer_if.sv
// lane_renderer_if: pixel request in, colour word out.
// The renderer is the slave. The pixel scanner and the vgac sink are the master.
interface lane_renderer_if;
  logic        pix_req;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] color;
  logic        color_valid;

  modport master (output pix_req, output x, output y, input color, input color_valid);
  modport slave  (input pix_req, input x, input y, output color, output color_valid);
endinterface

// File: rtl/lane_renderer.sv
// lane_renderer: parametrised N-lane rhythm playfield colour generator.
// Fixed 2-cycle latency. There is no stall. Each lane has a hit-flash timer counted in frames.
// Optional feature: define MISS_FLASH_EN for per-lane miss flags. A lane with its flag set flashes blue instead of grey.
module lane_renderer #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned LEFT_X       = 50,
  parameter int unsigned LANE_W       = 100,
  parameter int unsigned BORDER_W     = 6,
  parameter int unsigned JUDGE_Y      = 440,
  parameter int unsigned TRACK_H      = 480,
  parameter int unsigned FLASH_FRAMES = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  lane_renderer_if.slave           pix,
  input  logic [LANES-1:0]         keys,
  input  logic [LANES*TRACK_H-1:0] notes,
  input  logic [LANES-1:0]         hit,
  input  logic [LANES-1:0]         miss
);
  localparam int unsigned PITCH   = LANE_W + BORDER_W;
  localparam int unsigned RIGHT_X = LEFT_X + LANES*PITCH + BORDER_W - 1;
  localparam int unsigned KEY_Y   = JUDGE_Y + BORDER_W;
  localparam logic [3:0]  FLASH_LOAD = 4'(FLASH_FRAMES);

  typedef enum logic [1:0] {REG_OUT, REG_BORDER, REG_KEY, REG_NOTE} region_e;

  logic [3:0]       flash_q [LANES];
  logic [3:0]       flash_d [LANES];
  logic [LANES-1:0] miss_flag;
  logic             frame_start;

  region_e      region_d, region_q;
  logic         v1_d, v1_q, key_d, key_q, note_d, note_q;
  logic         flash_nz_d, flash_nz_q, missf_sel_d, missf_sel_q;
  logic         v2_d, v2_q;
  logic [11:0]  color_d, color_q;
  logic [31:0]  xu, yu;
  logic [TRACK_H-1:0] lane_bits;

  assign frame_start = pix.pix_req && (pix.x == '0) && (pix.y == '0);

`ifdef MISS_FLASH_EN
  logic [LANES-1:0] missf_q, missf_d;

  // Miss flag: a miss sets the flag and a hit clears it. The flag also drops when the timer runs out.
  always_comb begin
    missf_d = missf_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (miss[i]) missf_d[i] = 1'b1;
      if (hit[i]) missf_d[i] = 1'b0;
      if (flash_d[i] == '0) missf_d[i] = 1'b0;
    end
  end

  // Miss flag storage
  always_ff @(posedge clk) begin
    if (rst) missf_q <= '0;
    else     missf_q <= missf_d;
  end

  assign miss_flag = missf_q;
`else
  logic miss_unused;
  assign miss_unused = ^miss;
  assign miss_flag   = '0;
`endif

  // Flash timers: a load beats a decrement in the same cycle, and the count holds at zero
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      flash_d[i] = flash_q[i];
      if (frame_start && flash_q[i] != '0) flash_d[i] = flash_q[i] - 4'd1;
`ifdef MISS_FLASH_EN
      if (miss[i]) flash_d[i] = FLASH_LOAD;
`endif
      if (hit[i]) flash_d[i] = FLASH_LOAD;
    end
  end

  // Stage 1: classify the pixel with per-lane parallel comparators and capture that lane's attributes
  always_comb begin
    xu          = {22'd0, pix.x};
    yu          = {23'd0, pix.y};
    v1_d        = pix.pix_req;
    region_d    = REG_OUT;
    key_d       = 1'b0;
    note_d      = 1'b0;
    flash_nz_d  = 1'b0;
    missf_sel_d = 1'b0;
    lane_bits   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (xu >= LEFT_X + i*PITCH + BORDER_W && xu < LEFT_X + i*PITCH + BORDER_W + LANE_W) begin
        lane_bits   = notes[i*TRACK_H +: TRACK_H];
        key_d       = keys[i];
        flash_nz_d  = (flash_q[i] != '0);
        missf_sel_d = miss_flag[i];
        if (yu >= KEY_Y) begin
          region_d = REG_KEY;
        end else if (yu < JUDGE_Y) begin
          region_d = REG_NOTE;
          note_d   = (yu < TRACK_H) && lane_bits[pix.y];
        end
      end
    end
    // Border columns and the judge line override whatever lane classification was made above
    for (int unsigned i = 0; i <= LANES; i++) begin
      if (xu >= LEFT_X + i*PITCH && xu < LEFT_X + i*PITCH + BORDER_W) region_d = REG_BORDER;
    end
    if (yu >= JUDGE_Y && yu < KEY_Y && xu >= LEFT_X && xu <= RIGHT_X) region_d = REG_BORDER;
  end

  // Stage 2: resolve the colour priority from the stage-1 attributes
  always_comb begin
    v2_d    = v1_q;
    color_d = 12'h000;
    if (v1_q) begin
      unique case (region_q)
        REG_BORDER: color_d = 12'hFFF;
        REG_KEY:    color_d = key_q ? 12'h777 : 12'h444;
        REG_NOTE: begin
          if (note_q)          color_d = 12'hF00;
          else if (flash_nz_q) color_d = missf_sel_q ? 12'h00F : 12'hCCC;
          else                 color_d = key_q ? 12'h777 : 12'h000;
        end
        default:    color_d = 12'h000;
      endcase
    end
  end

  // Pipeline and flash-timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) flash_q[i] <= '0;
      v1_q        <= 1'b0;
      region_q    <= REG_OUT;
      key_q       <= 1'b0;
      note_q      <= 1'b0;
      flash_nz_q  <= 1'b0;
      missf_sel_q <= 1'b0;
      v2_q        <= 1'b0;
      color_q     <= 12'h000;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) flash_q[i] <= flash_d[i];
      v1_q        <= v1_d;
      region_q    <= region_d;
      key_q       <= key_d;
      note_q      <= note_d;
      flash_nz_q  <= flash_nz_d;
      missf_sel_q <= missf_sel_d;
      v2_q        <= v2_d;
      color_q     <= color_d;
    end
  end

  assign pix.color       = color_q;
  assign pix.color_valid = v2_q;
endmodule
